// File: rtl/hwpe_ctrl_periph_arbiter_pkg.sv
// Shared HWPE control constants: mandatory register indices and the
// peripheral arbiter lock-FSM state encoding.
package hwpe_ctrl_package;

    localparam int REGFILE_N_REGISTERS          = 64;
    localparam int LOG_REGS                     = $clog2(REGFILE_N_REGISTERS);

    localparam int REGFILE_MANDATORY_TRIGGER     = 0;
    localparam int REGFILE_MANDATORY_ACQUIRE     = 1;
    localparam int REGFILE_MANDATORY_FINISHED    = 2;
    localparam int REGFILE_MANDATORY_STATUS      = 3;
    localparam int REGFILE_MANDATORY_RUNNING_JOB = 4;
    localparam int REGFILE_MANDATORY_SOFTCLEAR   = 5;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQ_PEND = 2'd1,
        LOCKED   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/hwpe_ctrl_periph_arbiter_if.sv
// Peripheral configuration bus between the arbiter and hwpe_ctrl_slave.
// Handshake: a request transfers in any cycle where req && gnt are both high;
// the slave answers with r_valid (plus r_data/r_id) exactly one cycle later.
interface hwpe_ctrl_intf_periph #(
    parameter int ID_WIDTH = 16
) ();
    logic                req;
    logic                gnt;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/hwpe_ctrl_periph_arbiter_rr_arb.sv
// Round-robin priority selector: the first asserted request at or after
// i_ptr (wrapping) wins; output is one-hot or zero.
module hwpe_ctrl_rr_arb #(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);

    always_comb begin
        logic found;
        int   j;
        o_gnt = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(i_ptr) + i) % N;
            if (!found && i_req[j]) begin
                o_gnt[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hwpe_ctrl_periph_arbiter.sv
// N-core arbiter in front of hwpe_ctrl_slave with an acquire/trigger lock.
// Define HWPE_CTRL_ARB_TIMEOUT_EN to force-release an idle lock (timeout_o).
module hwpe_ctrl_periph_arbiter
    import hwpe_ctrl_package::*;
#(
    parameter int N_REQ        = 4,
    parameter int ID_WIDTH     = 16,
    parameter int LOCK_TIMEOUT = 1024,
    localparam int PW = $clog2(N_REQ)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    input  logic [N_REQ-1:0]                req_i,
    output logic [N_REQ-1:0]                gnt_o,
    input  logic [N_REQ-1:0][31:0]          add_i,
    input  logic [N_REQ-1:0]                wen_i,
    input  logic [N_REQ-1:0][3:0]           be_i,
    input  logic [N_REQ-1:0][31:0]          data_i,
    input  logic [N_REQ-1:0][ID_WIDTH-1:0]  id_i,
    output logic [31:0]                     r_data_o,
    output logic [N_REQ-1:0]                r_valid_o,
    output logic [ID_WIDTH-1:0]             r_id_o,
    hwpe_ctrl_intf_periph.master            cfg,
    output logic [PW-1:0]                   lock_owner_o,
    output logic                            locked_o,
    output arb_state_e                      state_o
`ifdef HWPE_CTRL_ARB_TIMEOUT_EN
    ,
    output logic                            timeout_o
`endif
);

    arb_state_e       r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_owner;
    logic [PW-1:0]    r_idx;
    logic             r_pend;

    logic [N_REQ-1:0]    w_owner_oh;
    logic [N_REQ-1:0]    w_elig;
    logic [N_REQ-1:0]    w_win_oh;
    logic [PW-1:0]       w_win_idx;
    logic                w_grant;
    logic [LOG_REGS-1:0] w_reg_idx;
    logic                w_acq;
    logic                w_trig;
    logic                w_resp;

    assign w_owner_oh = N_REQ'(1) << r_owner;
    assign w_elig     = (r_state == UNLOCKED) ? req_i : (req_i & w_owner_oh);

    hwpe_ctrl_rr_arb #(
        .N (N_REQ)
    ) i_rr_arb (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_win_oh)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win_oh[i]) w_win_idx = PW'(i);
        end
    end

    // Reset gates the grant so nothing leaks out while rst_ni is low.
    assign gnt_o    = w_win_oh & {N_REQ{cfg.gnt & rst_ni}};
    assign w_grant  = |gnt_o;
    assign cfg.req  = w_grant;
    assign cfg.add  = add_i[w_win_idx];
    assign cfg.wen  = wen_i[w_win_idx];
    assign cfg.be   = be_i[w_win_idx];
    assign cfg.data = data_i[w_win_idx];
    assign cfg.id   = id_i[w_win_idx];

    assign w_reg_idx = cfg.add[LOG_REGS+1:2];
    assign w_acq     = w_grant &  cfg.wen & (w_reg_idx == LOG_REGS'(REGFILE_MANDATORY_ACQUIRE));
    assign w_trig    = w_grant & ~cfg.wen & (w_reg_idx == LOG_REGS'(REGFILE_MANDATORY_TRIGGER));
    assign w_resp    = cfg.r_valid & r_pend;

    assign r_valid_o    = w_resp ? (N_REQ'(1) << r_idx) : '0;
    assign r_data_o     = cfg.r_data;
    assign r_id_o       = cfg.r_id;
    assign locked_o     = (r_state != UNLOCKED);
    assign lock_owner_o = r_owner;
    assign state_o      = r_state;

`ifdef HWPE_CTRL_ARB_TIMEOUT_EN
    localparam int TW = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    logic [TW-1:0] r_tmo_cnt;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= UNLOCKED;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_idx     <= '0;
            r_pend    <= 1'b0;
`ifdef HWPE_CTRL_ARB_TIMEOUT_EN
            r_tmo_cnt <= '0;
            timeout_o <= 1'b0;
`endif
        end else begin
            // Response routing is independent of clear so in-flight reads land.
            r_pend <= w_grant;
            if (w_grant) r_idx <= w_win_idx;
`ifdef HWPE_CTRL_ARB_TIMEOUT_EN
            timeout_o <= 1'b0;
`endif
            if (clear_i) begin
                r_state   <= UNLOCKED;
                r_ptr     <= '0;
`ifdef HWPE_CTRL_ARB_TIMEOUT_EN
                r_tmo_cnt <= '0;
`endif
            end else begin
                if (w_grant) begin
                    r_ptr <= (w_win_idx == PW'(N_REQ-1)) ? '0 : w_win_idx + 1'b1;
                end
                case (r_state)
                    UNLOCKED: begin
                        if (w_acq) begin
                            r_state <= ACQ_PEND;
                            r_owner <= w_win_idx;
                        end
                    end
                    ACQ_PEND: begin
                        // Bit 31 of the acquire read-back flags a failed acquire.
                        if (w_resp) r_state <= cfg.r_data[31] ? UNLOCKED : LOCKED;
                    end
                    LOCKED: begin
                        if (w_trig) r_state <= UNLOCKED;
`ifdef HWPE_CTRL_ARB_TIMEOUT_EN
                        if (w_grant) begin
                            r_tmo_cnt <= '0;
                        end else if (r_tmo_cnt == TW'(LOCK_TIMEOUT-1)) begin
                            r_state   <= UNLOCKED;
                            r_tmo_cnt <= '0;
                            timeout_o <= 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
`endif
                    end
                    default: r_state <= UNLOCKED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_periph_arbiter.sv
// Directed bench for hwpe_ctrl_periph_arbiter: vector table plus lock,
// timeout (HWPE_CTRL_ARB_TIMEOUT_EN) and async-reset sequences.
module tb_hwpe_ctrl_periph_arbiter;
    import hwpe_ctrl_package::*;

    localparam int N  = 4;
    localparam int IW = 16;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  clear_i;
    logic [N-1:0]          req_i;
    logic [N-1:0]          gnt_o;
    logic [N-1:0][31:0]    add_i;
    logic [N-1:0]          wen_i;
    logic [N-1:0][3:0]     be_i;
    logic [N-1:0][31:0]    data_i;
    logic [N-1:0][IW-1:0]  id_i;
    logic [31:0]           r_data_o;
    logic [N-1:0]          r_valid_o;
    logic [IW-1:0]         r_id_o;
    logic [1:0]            lock_owner_o;
    logic                  locked_o;
    arb_state_e            state_o;
`ifdef HWPE_CTRL_ARB_TIMEOUT_EN
    logic                  timeout_o;
`endif

    logic                  slv_gnt;
    logic                  acq_fail;
    logic                  s_rvalid;
    logic [31:0]           s_rdata;
    logic [IW-1:0]         s_rid;

    int n_checks = 0;
    int n_fail   = 0;

    hwpe_ctrl_intf_periph #(.ID_WIDTH(IW)) cfg ();

    hwpe_ctrl_periph_arbiter #(
        .N_REQ        (N),
        .ID_WIDTH     (IW),
        .LOCK_TIMEOUT (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .add_i        (add_i),
        .wen_i        (wen_i),
        .be_i         (be_i),
        .data_i       (data_i),
        .id_i         (id_i),
        .r_data_o     (r_data_o),
        .r_valid_o    (r_valid_o),
        .r_id_o       (r_id_o),
        .cfg          (cfg),
        .lock_owner_o (lock_owner_o),
        .locked_o     (locked_o),
        .state_o      (state_o)
`ifdef HWPE_CTRL_ARB_TIMEOUT_EN
        ,
        .timeout_o    (timeout_o)
`endif
    );

    // Clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Slave model: grants when slv_gnt, answers one cycle later. Acquire reads
    // return 0 or all-ones (failure); other accesses echo the ID.
    assign cfg.gnt     = slv_gnt;
    assign cfg.r_valid = s_rvalid;
    assign cfg.r_data  = s_rdata;
    assign cfg.r_id    = s_rid;

    always @(posedge clk_i) begin
        s_rvalid <= cfg.req & cfg.gnt;
        s_rid    <= cfg.id;
        if (cfg.wen && cfg.add[7:2] == 6'd1)
            s_rdata <= acq_fail ? 32'hFFFF_FFFF : 32'h0;
        else
            s_rdata <= {16'h5A00, cfg.id};
    end

    typedef struct {
        logic            clr;
        logic            sgnt;
        logic [3:0]      req;
        logic [3:0]      wen;
        logic [3:0][5:0] rg;
        logic            afail;
        logic [3:0]      egnt;
        logic [3:0]      erv;
        logic            elock;
        logic [1:0]      eown;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic clr, input logic sgnt, input logic [3:0] req,
                                input logic [3:0] wen, input logic [23:0] rg, input logic afail,
                                input logic [3:0] egnt, input logic [3:0] erv,
                                input logic elock, input logic [1:0] eown);
        vec_t v;
        v.clr = clr; v.sgnt = sgnt; v.req = req; v.wen = wen; v.rg = rg;
        v.afail = afail; v.egnt = egnt; v.erv = erv; v.elock = elock; v.eown = eown;
        return v;
    endfunction

    // Driver tasks
    task automatic drive(input vec_t v);
        clear_i  = v.clr;
        slv_gnt  = v.sgnt;
        req_i    = v.req;
        wen_i    = v.wen;
        acq_fail = v.afail;
        for (int i = 0; i < N; i++) add_i[i] = 32'(v.rg[i]) << 2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    localparam logic [23:0] R_ST  = {6'd3, 6'd3, 6'd3, 6'd3};
    localparam logic [23:0] R_A2  = {6'd3, 6'd1, 6'd3, 6'd3};
    localparam logic [23:0] R_T2  = {6'd3, 6'd0, 6'd3, 6'd3};
    localparam logic [23:0] R_A1  = {6'd3, 6'd3, 6'd1, 6'd3};

    initial begin
        vec_t idle;
        int   hit;

        // round robin 0..3, response one cycle after each grant
        vecs[0]  = mk(0, 1, 4'b1111, 4'b1111, R_ST, 0, 4'b0001, 4'b0000, 0, 2'd0);
        vecs[1]  = mk(0, 1, 4'b1111, 4'b1111, R_ST, 0, 4'b0010, 4'b0001, 0, 2'd0);
        vecs[2]  = mk(0, 1, 4'b1111, 4'b1111, R_ST, 0, 4'b0100, 4'b0010, 0, 2'd0);
        vecs[3]  = mk(0, 1, 4'b1111, 4'b1111, R_ST, 0, 4'b1000, 4'b0100, 0, 2'd0);
        vecs[4]  = mk(0, 1, 4'b0000, 4'b1111, R_ST, 0, 4'b0000, 4'b1000, 0, 2'd0);
        vecs[5]  = mk(0, 1, 4'b0000, 4'b1111, R_ST, 0, 4'b0000, 4'b0000, 0, 2'd0);
        // requester 2 acquires, requester 0 stalled until the trigger write
        vecs[6]  = mk(0, 1, 4'b0100, 4'b0100, R_A2, 0, 4'b0100, 4'b0000, 0, 2'd0);
        vecs[7]  = mk(0, 1, 4'b0001, 4'b0001, R_ST, 0, 4'b0000, 4'b0100, 1, 2'd2);
        vecs[8]  = mk(0, 1, 4'b0001, 4'b0001, R_ST, 0, 4'b0000, 4'b0000, 1, 2'd2);
        vecs[9]  = mk(0, 1, 4'b0101, 4'b0001, R_T2, 0, 4'b0100, 4'b0000, 1, 2'd2);
        vecs[10] = mk(0, 1, 4'b0001, 4'b0001, R_ST, 0, 4'b0001, 4'b0100, 0, 2'd2);
        vecs[11] = mk(0, 1, 4'b0000, 4'b0001, R_ST, 0, 4'b0000, 4'b0001, 0, 2'd2);
        // failed acquire by requester 1
        vecs[12] = mk(0, 1, 4'b0010, 4'b0010, R_A1, 1, 4'b0010, 4'b0000, 0, 2'd2);
        vecs[13] = mk(0, 1, 4'b0000, 4'b0010, R_ST, 1, 4'b0000, 4'b0010, 1, 2'd1);
        vecs[14] = mk(0, 1, 4'b0000, 4'b0010, R_ST, 0, 4'b0000, 4'b0000, 0, 2'd1);
        // lock by 1, clear in the cycle of an owner read; pointer back to 0
        vecs[15] = mk(0, 1, 4'b0010, 4'b0010, R_A1, 0, 4'b0010, 4'b0000, 0, 2'd1);
        vecs[16] = mk(0, 1, 4'b0000, 4'b0010, R_ST, 0, 4'b0000, 4'b0010, 1, 2'd1);
        vecs[17] = mk(1, 1, 4'b0010, 4'b0010, R_ST, 0, 4'b0010, 4'b0000, 1, 2'd1);
        vecs[18] = mk(0, 1, 4'b0101, 4'b0101, R_ST, 0, 4'b0001, 4'b0010, 0, 2'd1);
        vecs[19] = mk(0, 1, 4'b0000, 4'b0101, R_ST, 0, 4'b0000, 4'b0001, 0, 2'd1);
        // slave withholding gnt suppresses the grant
        vecs[20] = mk(0, 0, 4'b0010, 4'b0010, R_ST, 0, 4'b0000, 4'b0000, 0, 2'd1);
        vecs[21] = mk(0, 1, 4'b0010, 4'b0010, R_ST, 0, 4'b0010, 4'b0000, 0, 2'd1);
        vecs[22] = mk(0, 1, 4'b0000, 4'b0010, R_ST, 0, 4'b0000, 4'b0010, 0, 2'd1);
        idle = vecs[5];

        for (int i = 0; i < N; i++) begin
            be_i[i]   = 4'hF;
            data_i[i] = 32'hDA7A_0000 + 32'(i);
            id_i[i]   = IW'(16'h100 + i);
        end

        // reset state, with all requests asserted
        rst_ni = 1'b0;
        drive(vecs[0]);
        #3;
        check("rst_gnt",    32'(gnt_o),        32'h0);
        check("rst_rvalid", 32'(r_valid_o),    32'h0);
        check("rst_locked", 32'(locked_o),     32'h0);
        check("rst_owner",  32'(lock_owner_o), 32'h0);
        check("rst_cfgreq", 32'(cfg.req),      32'h0);
        check("rst_state",  32'(state_o),      32'(UNLOCKED));
        @(negedge clk_i);
        drive(idle);
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk_i);
            #1;
            drive(vecs[i]);
            @(negedge clk_i);
            check($sformatf("v%0d_gnt", i),    32'(gnt_o),        32'(vecs[i].egnt));
            check($sformatf("v%0d_rvalid", i), 32'(r_valid_o),    32'(vecs[i].erv));
            check($sformatf("v%0d_locked", i), 32'(locked_o),     32'(vecs[i].elock));
            check($sformatf("v%0d_owner", i),  32'(lock_owner_o), 32'(vecs[i].eown));
            check($sformatf("v%0d_cfgreq", i), 32'(cfg.req),      32'(|vecs[i].egnt));
            for (int k = 0; k < N; k++) begin
                if (vecs[i].egnt[k]) begin
                    check($sformatf("v%0d_fwd_id", i),   32'(cfg.id), 32'h100 + 32'(k));
                    check($sformatf("v%0d_fwd_data", i), cfg.data,    32'hDA7A_0000 + 32'(k));
                    check($sformatf("v%0d_fwd_add", i),  cfg.add,     32'(vecs[i].rg[k]) << 2);
                end
                if (vecs[i].erv[k])
                    check($sformatf("v%0d_rid", i), 32'(r_id_o), 32'h100 + 32'(k));
            end
        end
        @(posedge clk_i);
        #1;
        drive(idle);

`ifdef HWPE_CTRL_ARB_TIMEOUT_EN
        // lock by requester 2, owner idle, requester 1 waiting
        @(posedge clk_i);
        #1;
        drive(mk(0, 1, 4'b0100, 4'b0100, R_A2, 0, 0, 0, 0, 0));
        @(posedge clk_i);
        #1;
        drive(idle);
        @(posedge clk_i);
        #1;
        drive(mk(0, 1, 4'b0010, 4'b0010, R_ST, 0, 0, 0, 0, 0));
        hit = 0;
        for (int k = 1; k <= 20 && hit == 0; k++) begin
            @(negedge clk_i);
            if (timeout_o) hit = k;
            else check($sformatf("tmo_hold_gnt_%0d", k), 32'(gnt_o), 32'h0);
        end
        check("tmo_cycle",  32'(hit),      32'd9);
        check("tmo_gnt",    32'(gnt_o),    32'b0010);
        check("tmo_locked", 32'(locked_o), 32'h0);
        @(negedge clk_i);
        check("tmo_pulse_end", 32'(timeout_o), 32'h0);
        @(posedge clk_i);
        #1;
        drive(idle);
`endif

        // lock by requester 2, then async reset with an owner read in flight
        @(posedge clk_i);
        #1;
        drive(mk(0, 1, 4'b0100, 4'b0100, R_A2, 0, 0, 0, 0, 0));
        @(posedge clk_i);
        #1;
        drive(idle);
        @(posedge clk_i);
        #1;
        drive(mk(0, 1, 4'b0101, 4'b0101, R_ST, 0, 0, 0, 0, 0));
        @(negedge clk_i);
        check("pre_rst_gnt",    32'(gnt_o),        32'b0100);
        check("pre_rst_locked", 32'(locked_o),     32'h1);
        check("pre_rst_owner",  32'(lock_owner_o), 32'h2);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_gnt",    32'(gnt_o),        32'h0);
        check("arst_rvalid", 32'(r_valid_o),    32'h0);
        check("arst_locked", 32'(locked_o),     32'h0);
        check("arst_owner",  32'(lock_owner_o), 32'h0);
        check("arst_cfgreq", 32'(cfg.req),      32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("post_rst_gnt",    32'(gnt_o),    32'b0001);
        check("post_rst_locked", 32'(locked_o), 32'h0);
        @(posedge clk_i);
        #1;
        drive(idle);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hwpe_ctrl_periph_arbiter.md
HWPE_CTRL_PERIPH_ARBITER -- requirements
Module: hwpe_ctrl_periph_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of upstream requesters (cores); SHALL be 2..16.
REQ-002 Parameter ID_WIDTH, default 16: width of the upstream and downstream ID fields.
REQ-003 Parameter LOCK_TIMEOUT, default 1024: idle cycles before a held lock is forcibly released.
REQ-004 clk_i  in  1  clock; the block SHALL use one clock only.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 clear_i  in  1  soft clear; connected to the slave clear_o.
REQ-007 req_i  in  N_REQ  per-requester request.
REQ-008 gnt_o  out  N_REQ  per-requester grant; one-hot or zero.
REQ-009 add_i  in  N_REQ x 32  address.
REQ-010 wen_i  in  N_REQ  1 means read, 0 means write.
REQ-011 be_i  in  N_REQ x 4  byte enables.
REQ-012 data_i  in  N_REQ x 32  write data.
REQ-013 id_i  in  N_REQ x ID_WIDTH  requester ID.
REQ-014 r_data_o  out  32  read data, shared by all requesters.
REQ-015 r_valid_o  out  N_REQ  per-requester response valid.
REQ-016 r_id_o  out  ID_WIDTH  response ID.
REQ-017 cfg  hwpe_ctrl_intf_periph.master  -  downstream port to hwpe_ctrl_slave.
REQ-018 lock_owner_o  out  $clog2(N_REQ)  index of the current lock owner.
REQ-019 locked_o  out  1  a lock is currently held.

Function
REQ-020 Arbitration SHALL be round-robin over eligible requesters, with at most one grant per cycle.
REQ-021 gnt_o SHALL be combinational in the request cycle and SHALL be gated by cfg.gnt.
REQ-022 After a grant, the priority pointer SHALL be set to the granted index + 1, modulo N_REQ.
REQ-023 The winner's add, wen, be, data and id SHALL be forwarded onto cfg in the same cycle; cfg.req SHALL equal the OR of gnt_o.
REQ-024 The granted index SHALL be registered in the grant cycle.
REQ-025 On the next cycle's cfg.r_valid, r_valid_o[registered index] SHALL be asserted; r_data_o SHALL equal cfg.r_data and r_id_o SHALL equal cfg.r_id.
REQ-026 The FSM SHALL have three states: UNLOCKED, ACQ_PEND, LOCKED.
REQ-027 UNLOCKED: all requesters are eligible; a granted read at register index REGFILE_MANDATORY_ACQUIRE SHALL move to ACQ_PEND and capture the owner index.
REQ-028 ACQ_PEND: only the owner is eligible.
REQ-029 ACQ_PEND: cfg.r_valid with r_data[31]==0 SHALL move to LOCKED; with r_data[31]==1 (acquire failed) SHALL move to UNLOCKED.
REQ-030 LOCKED: only the owner is eligible; other requests SHALL be held with gnt_o low.
REQ-031 LOCKED: an owner write at REGFILE_MANDATORY_TRIGGER SHALL be granted and SHALL move to UNLOCKED in the same edge.
REQ-032 Register index SHALL be add[LOG_REGS+1:2], taken from the shared package.
REQ-033 Simultaneous trigger from the owner and request from others: the trigger SHALL be granted; the others SHALL compete from the next cycle.
REQ-034 locked_o SHALL be 1 in ACQ_PEND and LOCKED.
REQ-035 lock_owner_o SHALL hold the last captured owner.
REQ-036 clear_i SHALL force UNLOCKED, pointer 0, timeout counter 0 at the next edge.
REQ-037 A pending response SHALL still be routed after clear_i.

Reset
REQ-038 On reset: state UNLOCKED, pointer 0, owner 0, registered index 0, timeout counter 0.
REQ-039 On reset: gnt_o, r_valid_o, locked_o and cfg.req SHALL be 0.
REQ-040 Assertion mid-transaction SHALL drop the pending response.

Configuration
REQ-041 Macro HWPE_CTRL_ARB_TIMEOUT_EN, when defined, SHALL enable a counter of LOCKED cycles without an owner grant.
REQ-042 The counter SHALL reset on each owner grant.
REQ-043 When the counter reaches LOCK_TIMEOUT-1, the FSM SHALL move to UNLOCKED and pulse timeout_o for 1 cycle.
REQ-044 Without the macro, the lock SHALL be released only by trigger, failed acquire, clear or reset; timeout_o SHALL be absent.

Structure
REQ-045 The FSM state enum SHALL live in hwpe_ctrl_package, alongside the existing REGFILE_MANDATORY_* and REGFILE_N_REGISTERS constants.
REQ-046 The round-robin priority selector SHALL be one sub-module, hwpe_ctrl_rr_arb (N inputs, pointer in, one-hot out).

Verification
REQ-047 Requesters 0–3 issue reads together for 4 cycles -> grants in order 0,1,2,3; each gets r_valid one cycle after its grant.
REQ-048 Requester 2 acquires, returning 0x0 -> locked_o=1, owner=2; requester 0 request stalled; requester 2 writes index 0 -> unlocked; requester 0 granted next cycle.
REQ-049 Acquire returns 0xFFFFFFFF -> FSM returns to UNLOCKED after the response; locked_o deasserted.
REQ-050 With TIMEOUT_EN and LOCK_TIMEOUT=8: lock, then owner idle for 8 cycles -> timeout_o pulse; requester 1 granted.
REQ-051 clear_i asserted while LOCKED with a read in flight -> response still routed; state UNLOCKED next cycle.
REQ-052 rst_ni dropped mid-LOCKED -> all outputs 0 asynchronously; first request after release is granted from index 0.
